tile_pixel_renderer: RTL and testbench
======================================

// Module: tile_pixel_renderer
// PURPOSE
//  Consumer of the image-ROM buses (background/wall RGB, dot/big-dot/player/ghost masks).
//  Per display pixel: takes the tile type from the map lookup, indexes the flattened
//  buses, and returns 4-bit RGB.
//  Two-stage pipeline between the map lookup and the VGA output register.
//  Owns the sprite animation frame select (f1/f2).
// PARAMETERS
//  TILE_SIZE    `tile_size  tile edge in pixels; must be a power of 2 (default 16)
//  ANIM_FRAMES  8           frame_tick pulses per f1/f2 toggle; must be >= 1
//  COORD_W      10          width of pix_x / pix_y
// PORTS
//  clk             in   1           system clock
//  rst             in   1           synchronous, active-high reset
//  frame_tick      in   1           one-cycle pulse per video frame
//  pix_valid       in   1           pixel request valid (display enable)
//  pix_x, pix_y    in   COORD_W     screen coordinates of the request
//  tile_type       in   3           tile code at (pix_x, pix_y)
//  background_r/g/b, wall_r/g/b  in  T*T*4   colour buses, T = TILE_SIZE
//  dot_mask, big_dot_mask        in  T*T     masks
//  player_mask_f1/f2, ghost_mask_f1/f2  in  T*T  masks
//  out_valid       out  1           RGB valid
//  vga_r, vga_g, vga_b  out  4      pixel colour
// BEHAVIOUR
//  - Reset: out_valid=0, vga_*=0, anim_cnt=0, anim_sel=0 (f1), both pipeline valids=0.
//    Reset mid-stream drops all in-flight pixels.
//  - No backpressure; every cycle with pix_valid=1 is accepted.
//  - Latency is exactly 2 cycles: out_valid(t+2) = pix_valid(t).
//  - Stage 1 registers:
//      lx = pix_x[log2T-1:0], ly = pix_y[log2T-1:0]
//      idx = ly*T + lx, width 2*log2T
//      tile_type, anim_sel, valid
//  - Stage 2 registers vga_* and out_valid.
//  - Colour select, using bg = background_*[idx*4 +: 4]:
//      EMPTY(0)   -> bg
//      WALL(1)    -> wall_*[idx*4 +: 4]
//      DOT(2)     -> dot_mask[idx] ? DOT_RGB : bg
//      BIGDOT(3)  -> big_dot_mask[idx] ? DOT_RGB : bg
//      PLAYER(4)  -> (anim_sel ? player_mask_f2 : player_mask_f1)[idx] ? PLAYER_RGB : bg
//      GHOST(5)   -> same form with the ghost masks and GHOST_RGB
//      codes 6, 7 -> bg
//  - Output valid low: vga_* driven 0 (blanking), not held.
//  - Animation:
//      on frame_tick: if anim_cnt == ANIM_FRAMES-1 then anim_cnt <= 0 and toggle anim_sel,
//      else anim_cnt <= anim_cnt+1.
//      The new anim_sel is seen by pixels sampled into stage 1 the cycle after the tick.
//      A pixel accepted in the tick cycle uses the old value.
//  - frame_tick during rst is ignored.
// CONFIGURATION
//  PLAYER_DIR_EN defined:
//  - Adds input player_dir [1:0]: 0=right, 1=left, 2=up, 3=down.
//  - player_dir is sampled in stage 1 and applies to PLAYER tiles only.
//  - Coordinate transform before idx:
//      right -> (lx, ly)
//      left  -> (T-1-lx, ly)
//      down  -> (ly, lx)
//      up    -> (ly, T-1-lx)
//  PLAYER_DIR_EN undefined:
//  - Port absent; player sprite always drawn untransformed (right-facing).
// STRUCTURE
//  - Shared package / include (pacman_render_pkg, alongside define.v):
//      tile codes TILE_EMPTY..TILE_GHOST
//      DOT_RGB = F,B,8; PLAYER_RGB = F,F,0; GHOST_RGB = F,0,0
//  - Sub-module tile_index_calc: (pix_x, pix_y, dir, is_player) -> idx.
//    Combinational; feeds the stage-1 register.
// TESTING (T=16, ANIM_FRAMES=8)
//  1. rst=1 for 3 cycles with pix_valid=1 -> out_valid=0, vga=0.
//     Deassert rst -> first out_valid exactly 2 cycles after the first accepted pixel.
//  2. WALL at (35,18); wall bus all (0,0,F) -> idx=35; vga=(0,0,F), out_valid=1, 2 cycles later.
//  3. PLAYER at (3,2): f1[35]=1, f2[35]=0 -> PLAYER_RGB.
//     After 8 frame_ticks -> background colour; after 16 -> PLAYER_RGB again.
//  4. DOT at (0,0) with dot_mask[0]=0 -> background_*[3:0].
//     tile_type=7 at same pixel -> background.
//  5. pix_valid 1,0,1 -> out_valid 1,0,1 shifted by 2 cycles; vga=0 in the gap.
//     rst asserted mid-burst -> out_valid=0 next cycle.
//  6. PLAYER_DIR_EN: dir=left at (0,0) reads player mask idx 15.
//     dir=down at (1,0) reads idx 16.
//     GHOST at (0,0) still reads idx 0.

Source files
------------

// File: rtl/tile_pixel_renderer_pkg.sv
// Shared types and constants for the tile pixel renderer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tile_pixel_renderer_pkg;

  localparam int DEF_TILE_SIZE = 16;

  // Tile codes coming from the map lookup; codes 6 and 7 are unused and draw background
  typedef enum logic [2:0] {
    TILE_EMPTY  = 3'd0,
    TILE_WALL   = 3'd1,
    TILE_DOT    = 3'd2,
    TILE_BIGDOT = 3'd3,
    TILE_PLAYER = 3'd4,
    TILE_GHOST  = 3'd5
  } tile_e;

  // Player facing direction
  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t DOT_RGB    = '{r: 4'hF, g: 4'hB, b: 4'h8};
  localparam rgb_t PLAYER_RGB = '{r: 4'hF, g: 4'hF, b: 4'h0};
  localparam rgb_t GHOST_RGB  = '{r: 4'hF, g: 4'h0, b: 4'h0};
  localparam rgb_t BLANK_RGB  = '{r: 4'h0, g: 4'h0, b: 4'h0};

endpackage

// File: rtl/tile_pixel_renderer_if.sv
// Pixel request / RGB response bundle between the VGA timing side and the renderer.
// Latency: responses follow requests by exactly 2 cycles.
// Backpressure: none; every valid request is taken.
interface tile_pixel_renderer_if #(
  parameter int COORD_W = 10
);
  logic               pix_valid;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic [2:0]         tile_type;
  logic               out_valid;
  logic [3:0]         vga_r;
  logic [3:0]         vga_g;
  logic [3:0]         vga_b;

  modport master (
    output pix_valid, pix_x, pix_y, tile_type,
    input  out_valid, vga_r, vga_g, vga_b
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, tile_type,
    output out_valid, vga_r, vga_g, vga_b
  );
endinterface

// File: rtl/tile_pixel_renderer_tile_index_calc.sv
// Maps in-tile coordinates (plus player facing) to a flat sprite index {y, x}.
// Latency: combinational; feeds the renderer's stage-1 register.
// Backpressure: n/a.
module tile_index_calc
  import tile_pixel_renderer_pkg::*;
#(
  parameter int LOG2T = 4
) (
  input  logic [LOG2T-1:0]   lx,        // pix_x modulo tile size
  input  logic [LOG2T-1:0]   ly,        // pix_y modulo tile size
  input  logic [1:0]         dir,
  input  logic               is_player,
  output logic [2*LOG2T-1:0] idx
);

  logic [LOG2T-1:0] tx;
  logic [LOG2T-1:0] ty;

  // Rotate/mirror the sprite lookup for the player only; T-1-lx is ~lx since T is a power of 2
  always_comb begin
    tx = lx;
    ty = ly;
    if (is_player) begin
      case (dir)
        DIR_LEFT: tx = ~lx;
        DIR_DOWN: begin
          tx = ly;
          ty = lx;
        end
        DIR_UP: begin
          tx = ly;
          ty = ~lx;
        end
        default: ;
      endcase
    end
    idx = {ty, tx};
  end

endmodule

// File: rtl/tile_pixel_renderer.sv
// Per-pixel tile renderer: tile type + ROM buses -> 4-bit RGB; owns sprite animation frame.
// Latency: 2 cycles (index register, then RGB register); out_valid(t+2) = pix_valid(t).
// Backpressure: none; every pix_valid cycle is accepted. Option macro: PLAYER_DIR_EN.
module tile_pixel_renderer
  import tile_pixel_renderer_pkg::*;
#(
  parameter int TILE_SIZE   = DEF_TILE_SIZE,
  parameter int ANIM_FRAMES = 8,
  parameter int COORD_W     = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              frame_tick,
`ifdef PLAYER_DIR_EN
  input  logic [1:0]                        player_dir,
`endif
  tile_pixel_renderer_if.slave              bus,
  input  logic [TILE_SIZE*TILE_SIZE*4-1:0]  background_r,
  input  logic [TILE_SIZE*TILE_SIZE*4-1:0]  background_g,
  input  logic [TILE_SIZE*TILE_SIZE*4-1:0]  background_b,
  input  logic [TILE_SIZE*TILE_SIZE*4-1:0]  wall_r,
  input  logic [TILE_SIZE*TILE_SIZE*4-1:0]  wall_g,
  input  logic [TILE_SIZE*TILE_SIZE*4-1:0]  wall_b,
  input  logic [TILE_SIZE*TILE_SIZE-1:0]    dot_mask,
  input  logic [TILE_SIZE*TILE_SIZE-1:0]    big_dot_mask,
  input  logic [TILE_SIZE*TILE_SIZE-1:0]    player_mask_f1,
  input  logic [TILE_SIZE*TILE_SIZE-1:0]    player_mask_f2,
  input  logic [TILE_SIZE*TILE_SIZE-1:0]    ghost_mask_f1,
  input  logic [TILE_SIZE*TILE_SIZE-1:0]    ghost_mask_f2
);

  localparam int LOG2T = $clog2(TILE_SIZE);
  localparam int IDX_W = 2 * LOG2T;
  localparam int CNT_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ANIM_FRAMES - 1);

  // Reject configurations the indexing scheme cannot handle
  if ((1 << LOG2T) != TILE_SIZE || LOG2T > COORD_W || ANIM_FRAMES < 1) begin : g_bad_cfg
    $error("tile_pixel_renderer: unsupported TILE_SIZE/COORD_W/ANIM_FRAMES");
  end

  logic [1:0]       dir_in;
  logic [IDX_W-1:0] idx_c;

`ifdef PLAYER_DIR_EN
  assign dir_in = player_dir;
`else
  assign dir_in = DIR_RIGHT;
`endif

  tile_index_calc #(.LOG2T(LOG2T)) u_idx (
    .lx        (bus.pix_x[LOG2T-1:0]),
    .ly        (bus.pix_y[LOG2T-1:0]),
    .dir       (dir_in),
    .is_player (bus.tile_type == TILE_PLAYER),
    .idx       (idx_c)
  );

  logic [CNT_W-1:0] anim_cnt;
  logic             anim_sel;

  // Frame counter: toggles the sprite frame every ANIM_FRAMES ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      anim_cnt <= '0;
      anim_sel <= 1'b0;
    end else if (frame_tick) begin
      if (anim_cnt == CNT_MAX) begin
        anim_cnt <= '0;
        anim_sel <= ~anim_sel;
      end else begin
        anim_cnt <= anim_cnt + 1'b1;
      end
    end
  end

  logic             s1_vld;
  logic [IDX_W-1:0] s1_idx;
  logic [2:0]       s1_type;
  logic             s1_sel;

  // Stage 1: capture index, tile type and the frame select in force this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_idx  <= '0;
      s1_type <= TILE_EMPTY;
      s1_sel  <= 1'b0;
    end else begin
      s1_vld  <= bus.pix_valid;
      s1_idx  <= idx_c;
      s1_type <= bus.tile_type;
      s1_sel  <= anim_sel;
    end
  end

  logic [IDX_W+1:0] nib;
  rgb_t             bg;
  rgb_t             pix_rgb;
  logic [TILE_SIZE*TILE_SIZE-1:0] player_mask;
  logic [TILE_SIZE*TILE_SIZE-1:0] ghost_mask;

  // Colour select: sprites and dots overlay the background wherever their mask bit is set
  always_comb begin
    nib         = {s1_idx, 2'b00};
    bg          = '{r: background_r[nib +: 4], g: background_g[nib +: 4], b: background_b[nib +: 4]};
    player_mask = s1_sel ? player_mask_f2 : player_mask_f1;
    ghost_mask  = s1_sel ? ghost_mask_f2  : ghost_mask_f1;
    pix_rgb     = bg;
    case (s1_type)
      TILE_WALL:   pix_rgb = '{r: wall_r[nib +: 4], g: wall_g[nib +: 4], b: wall_b[nib +: 4]};
      TILE_DOT:    if (dot_mask[s1_idx])     pix_rgb = DOT_RGB;
      TILE_BIGDOT: if (big_dot_mask[s1_idx]) pix_rgb = DOT_RGB;
      TILE_PLAYER: if (player_mask[s1_idx])  pix_rgb = PLAYER_RGB;
      TILE_GHOST:  if (ghost_mask[s1_idx])   pix_rgb = GHOST_RGB;
      default:     pix_rgb = bg;
    endcase
  end

  logic out_q;
  rgb_t vga_q;

  // Stage 2: output register, blanked to black whenever the pixel is not valid
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= 1'b0;
      vga_q <= BLANK_RGB;
    end else begin
      out_q <= s1_vld;
      vga_q <= s1_vld ? pix_rgb : BLANK_RGB;
    end
  end

  assign bus.out_valid = out_q;
  assign bus.vga_r     = vga_q.r;
  assign bus.vga_g     = vga_q.g;
  assign bus.vga_b     = vga_q.b;

endmodule

// File: tb/tb_tile_pixel_renderer.sv
// Bench for tile_pixel_renderer: directed steps with a scoreboard of expected RGB per cycle.
// Latency: checks the 2-cycle pipeline cycle by cycle.
// Backpressure: none to model. Option macro: PLAYER_DIR_EN.
module tb_tile_pixel_renderer;
  import tile_pixel_renderer_pkg::*;

  localparam int T  = 16;
  localparam int BW = T * T * 4;
  localparam int MW = T * T;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_tick = 1'b0;
  logic [1:0] player_dir = 2'd0;
  logic [BW-1:0] background_r, background_g, background_b;
  logic [BW-1:0] wall_r, wall_g, wall_b;
  logic [MW-1:0] dot_mask, big_dot_mask;
  logic [MW-1:0] player_mask_f1, player_mask_f2, ghost_mask_f1, ghost_mask_f2;

  tile_pixel_renderer_if #(.COORD_W(10)) bus ();

  tile_pixel_renderer #(.TILE_SIZE(T), .ANIM_FRAMES(8), .COORD_W(10)) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_tick     (frame_tick),
`ifdef PLAYER_DIR_EN
    .player_dir     (player_dir),
`endif
    .bus            (bus.slave),
    .background_r   (background_r),
    .background_g   (background_g),
    .background_b   (background_b),
    .wall_r         (wall_r),
    .wall_g         (wall_g),
    .wall_b         (wall_b),
    .dot_mask       (dot_mask),
    .big_dot_mask   (big_dot_mask),
    .player_mask_f1 (player_mask_f1),
    .player_mask_f2 (player_mask_f2),
    .ghost_mask_f1  (ghost_mask_f1),
    .ghost_mask_f2  (ghost_mask_f2)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          vld;
    logic [11:0] rgb;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   m_cnt    = 0;
  bit   m_sel    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference colour straight from the pixel rules, computed on integer coordinates
  function automatic logic [11:0] model_rgb(input int tt, input int x, input int y, input int dir, input bit sel);
    int lx, ly, px, py, i, pi;
    logic [11:0] bg;
    lx = x % T;
    ly = y % T;
    px = lx;
    py = ly;
    if (tt == 4) begin
      if (dir == 1) px = T - 1 - lx;
      else if (dir == 3) begin px = ly; py = lx; end
      else if (dir == 2) begin px = ly; py = T - 1 - lx; end
    end
    i  = ly * T + lx;
    pi = py * T + px;
    bg = {background_r[i*4 +: 4], background_g[i*4 +: 4], background_b[i*4 +: 4]};
    case (tt)
      1:       model_rgb = {wall_r[i*4 +: 4], wall_g[i*4 +: 4], wall_b[i*4 +: 4]};
      2:       model_rgb = dot_mask[i]     ? 12'hFB8 : bg;
      3:       model_rgb = big_dot_mask[i] ? 12'hFB8 : bg;
      4:       model_rgb = (sel ? player_mask_f2[pi] : player_mask_f1[pi]) ? 12'hFF0 : bg;
      5:       model_rgb = (sel ? ghost_mask_f2[i] : ghost_mask_f1[i]) ? 12'hF00 : bg;
      default: model_rgb = bg;
    endcase
  endfunction

  // One clock: drive inputs, push expectation, advance, compare the pixel due now
  task automatic cyc(input bit r, input bit v, input int x, input int y, input int tt,
                     input bit tick, input int dir);
    exp_t e;
    int   eff_dir;
`ifdef PLAYER_DIR_EN
    eff_dir = dir;
`else
    eff_dir = 0;
`endif
    rst           = r;
    frame_tick    = tick;
    bus.pix_valid = v;
    bus.pix_x     = 10'(x);
    bus.pix_y     = 10'(y);
    bus.tile_type = 3'(tt);
    player_dir    = 2'(dir);
    if (r) begin
      exp_q.delete();
      m_cnt = 0;
      m_sel = 1'b0;
    end else begin
      e.vld = v;
      e.rgb = v ? model_rgb(tt, x, y, eff_dir, m_sel) : 12'h000;
      exp_q.push_back(e);
      if (tick) begin
        if (m_cnt == 7) begin m_cnt = 0; m_sel = !m_sel; end
        else m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    if (exp_q.size() == 2) e = exp_q.pop_front();
    else begin e.vld = 1'b0; e.rgb = 12'h000; end
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, e.vld});
    chk("vga_rgb", {20'b0, bus.vga_r, bus.vga_g, bus.vga_b}, {20'b0, e.rgb});
  endtask

  initial begin
    for (int i = 0; i < MW; i++) begin
      background_r[i*4 +: 4] = 4'(i);
      background_g[i*4 +: 4] = 4'(i >> 4);
      background_b[i*4 +: 4] = 4'(15 - (i % 16));
      wall_r[i*4 +: 4]       = 4'h0;
      wall_g[i*4 +: 4]       = 4'h0;
      wall_b[i*4 +: 4]       = 4'hF;
      dot_mask[i]            = 1'($urandom_range(0, 1));
      big_dot_mask[i]        = 1'($urandom_range(0, 1));
      player_mask_f1[i]      = 1'($urandom_range(0, 1));
      player_mask_f2[i]      = 1'($urandom_range(0, 1));
      ghost_mask_f1[i]       = 1'($urandom_range(0, 1));
      ghost_mask_f2[i]       = 1'($urandom_range(0, 1));
    end
    dot_mask[0]        = 1'b0;
    player_mask_f1[35] = 1'b1;
    player_mask_f2[35] = 1'b0;
    player_mask_f1[0]  = 1'b0;
    player_mask_f1[15] = 1'b1;
    player_mask_f1[16] = 1'b1;
    player_mask_f1[1]  = 1'b0;
    ghost_mask_f1[0]   = 1'b1;

    // Reset held 3 cycles with requests and frame ticks present: nothing comes out, ticks ignored
    repeat (3) cyc(1, 1, 35, 18, 1, 1, 0);

    // Wall pixel at (35,18) -> idx 35, blue; appears exactly 2 cycles later
    cyc(0, 1, 35, 18, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("wall_latency_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("wall_rgb", {20'b0, bus.vga_r, bus.vga_g, bus.vga_b}, 32'h00F);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Player at (3,2): frame 1 draws sprite, after 8 ticks frame 2 shows background, 16 back again
    cyc(0, 1, 3, 2, 4, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    repeat (7) cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 3, 2, 4, 1, 0);   // accepted on the 8th tick: still frame 1
    cyc(0, 1, 3, 2, 4, 0, 0);   // first pixel after the toggle: frame 2
    cyc(0, 0, 0, 0, 0, 0, 0);
    repeat (8) cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 3, 2, 4, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("player_f1_again", {20'b0, bus.vga_r, bus.vga_g, bus.vga_b}, 32'hFF0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Empty dot and unused tile code both fall back to background idx 0
    cyc(0, 1, 0, 0, 2, 0, 0);
    cyc(0, 1, 0, 0, 7, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("code7_bg", {20'b0, bus.vga_r, bus.vga_g, bus.vga_b}, 32'h00F);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Patterned wall bus so wall indexing is exercised too
    for (int i = 0; i < MW; i++) begin
      wall_r[i*4 +: 4] = 4'(i % 7);
      wall_g[i*4 +: 4] = 4'(i % 11);
      wall_b[i*4 +: 4] = 4'(i >> 4);
    end

    // Mixed traffic: random tiles, positions, gaps and ticks
    for (int k = 0; k < 60; k++) begin
      cyc(0, ($urandom_range(0, 3) != 0), $urandom_range(0, 639), $urandom_range(0, 479),
          $urandom_range(0, 7), ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end

    // valid 1,0,1 -> out_valid 1,0,1 two cycles later with black in the gap
    cyc(0, 1, 5, 9, 0, 0, 0);
    cyc(0, 0, 6, 9, 0, 0, 0);
    cyc(0, 1, 7, 9, 0, 0, 0);
    cyc(0, 1, 8, 9, 1, 0, 0);
    // Reset mid-burst: in-flight pixels are dropped
    cyc(1, 1, 9, 9, 1, 0, 0);
    cyc(0, 1, 10, 9, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

`ifdef PLAYER_DIR_EN
    // Facing transforms: left (0,0)->15, down (1,0)->16, up (0,0)->240, ghost unaffected
    cyc(0, 1, 0, 0, 4, 0, 1);
    cyc(0, 1, 1, 0, 4, 0, 3);
    chk("dir_left_idx15", {20'b0, bus.vga_r, bus.vga_g, bus.vga_b}, 32'hFF0);
    cyc(0, 1, 0, 0, 4, 0, 2);
    chk("dir_down_idx16", {20'b0, bus.vga_r, bus.vga_g, bus.vga_b}, 32'hFF0);
    cyc(0, 1, 0, 0, 5, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("ghost_idx0", {20'b0, bus.vga_r, bus.vga_g, bus.vga_b}, 32'hF00);
`else
    // Without facing support the player is always right-facing: (0,0) reads idx 0 (clear)
    cyc(0, 1, 0, 0, 4, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("player_no_dir", {20'b0, bus.vga_r, bus.vga_g, bus.vga_b}, 32'h00F);
`endif
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
